// File: rtl/fc_serial_pkg.sv
// Shared constants and types for the Fibre Channel serial transmitter.
// Legal control characters are limited to K28.5 in the leading byte.
package fc_serial_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [9:0]  K28_5_RDN = 10'h0FA;
  localparam logic [9:0]  K28_5_RDP = 10'h305;
  localparam logic [31:0] FC_IDLE   = 32'hBC95B5B5;
  localparam logic [3:0]  FC_IDLE_K = 4'b1000;
  localparam int          WORD_BITS = 40;
  localparam int          NUM_LANES = 4;

  typedef logic [9:0] sym_t;

  // Only a K28.5 in the first character may be flagged as a control character.
  function automatic logic k_legal(input logic [31:0] data, input logic [3:0] k);
    return (k[2:0] == 3'b000) && (!k[3] || (data[31:24] == K28_5));
  endfunction

endpackage

// File: rtl/fc_8b10b_enc.sv
// Combinational 8b/10b encoder for one character (sym[9] = 'a', sym[0] = 'j').
// Control input k always produces K28.5; callers only pass k with 8'hBC.
module fc_8b10b_enc
  import fc_serial_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output sym_t       sym,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [6:0] t6;
  logic [4:0] t4;
  logic [5:0] s6;
  logic [3:0] s4;
  logic       rd_mid;
  logic       use_a7;

  assign x = data[4:0];
  assign y = data[7:5];

  // {alternates, RD- code}; alternating codes are complemented at RD+.
  always_comb begin
    t6 = 7'b0_000000;
    case (x)
      5'd0:    t6 = 7'b1_100111;
      5'd1:    t6 = 7'b1_011101;
      5'd2:    t6 = 7'b1_101101;
      5'd3:    t6 = 7'b0_110001;
      5'd4:    t6 = 7'b1_110101;
      5'd5:    t6 = 7'b0_101001;
      5'd6:    t6 = 7'b0_011001;
      5'd7:    t6 = 7'b1_111000;
      5'd8:    t6 = 7'b1_111001;
      5'd9:    t6 = 7'b0_100101;
      5'd10:   t6 = 7'b0_010101;
      5'd11:   t6 = 7'b0_110100;
      5'd12:   t6 = 7'b0_001101;
      5'd13:   t6 = 7'b0_101100;
      5'd14:   t6 = 7'b0_011100;
      5'd15:   t6 = 7'b1_010111;
      5'd16:   t6 = 7'b1_011011;
      5'd17:   t6 = 7'b0_100011;
      5'd18:   t6 = 7'b0_010011;
      5'd19:   t6 = 7'b0_110010;
      5'd20:   t6 = 7'b0_001011;
      5'd21:   t6 = 7'b0_101010;
      5'd22:   t6 = 7'b0_011010;
      5'd23:   t6 = 7'b1_111010;
      5'd24:   t6 = 7'b1_110011;
      5'd25:   t6 = 7'b0_100110;
      5'd26:   t6 = 7'b0_010110;
      5'd27:   t6 = 7'b1_110110;
      5'd28:   t6 = 7'b0_001110;
      5'd29:   t6 = 7'b1_101110;
      5'd30:   t6 = 7'b1_011110;
      default: t6 = 7'b1_101011;
    endcase
  end

  assign s6     = (t6[6] && rd_in) ? ~t6[5:0] : t6[5:0];
  // D.07 alternates but is balanced, so it leaves disparity alone.
  assign rd_mid = rd_in ^ (t6[6] && (x != 5'd7));
  assign use_a7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                         : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));

  always_comb begin
    t4 = 5'b0_0000;
    case (y)
      3'd0:    t4 = 5'b1_1011;
      3'd1:    t4 = 5'b0_1001;
      3'd2:    t4 = 5'b0_0101;
      3'd3:    t4 = 5'b1_1100;
      3'd4:    t4 = 5'b1_1101;
      3'd5:    t4 = 5'b0_1010;
      3'd6:    t4 = 5'b0_0110;
      default: t4 = use_a7 ? 5'b1_0111 : 5'b1_1110;
    endcase
  end

  assign s4 = (t4[4] && rd_mid) ? ~t4[3:0] : t4[3:0];

  always_comb begin
    if (k) begin
      sym    = rd_in ? K28_5_RDP : K28_5_RDN;
      rd_out = ~rd_in;
    end else begin
      sym    = {s6, s4};
      rd_out = rd_mid ^ (t4[4] && (y != 3'd3));
    end
  end

endmodule

// File: rtl/fc_serial_tx.sv
// FC serial transmitter: encodes one 32-bit word per 40 line bits, MSB first,
// substituting the fill word when no legal word is offered at the load edge.
module fc_serial_tx
  import fc_serial_pkg::*;
#(
  parameter logic [31:0] FILL_WORD = FC_IDLE,
  parameter logic [3:0]  FILL_K    = FC_IDLE_K
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_k,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_serial_data,
  output logic        tx_word_start,
  output logic        tx_rd,
  output logic        code_err
);

  localparam logic [5:0] LAST_BIT = 6'(WORD_BITS - 1);

  logic [5:0]                bit_cnt;
  logic [WORD_BITS-1:0]      shift_q;
  logic [NUM_LANES-1:0][7:0] lane_data;
  logic [NUM_LANES-1:0]      lane_k;
  sym_t [NUM_LANES-1:0]      lane_sym;
  logic [NUM_LANES:0]        rd_chain;
  logic                      in_legal;
  logic                      take_word;

  assign in_ready  = (bit_cnt == LAST_BIT);
  assign in_legal  = k_legal(in_data, in_k);
  assign take_word = in_valid && in_legal;
  assign lane_data = take_word ? in_data : FILL_WORD;
  assign lane_k    = take_word ? in_k    : FILL_K;

  // Lane NUM_LANES-1 is the first character on the line, so disparity flows downward.
  assign rd_chain[NUM_LANES] = tx_rd;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fc_8b10b_enc u_enc (
      .data   (lane_data[i]),
      .k      (lane_k[i]),
      .rd_in  (rd_chain[i+1]),
      .sym    (lane_sym[i]),
      .rd_out (rd_chain[i])
    );
  end

  assign tx_serial_data = shift_q[WORD_BITS-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt       <= LAST_BIT;
      shift_q       <= '0;
      tx_word_start <= 1'b0;
      tx_rd         <= 1'b0;
      code_err      <= 1'b0;
    end else if (in_ready) begin
      bit_cnt       <= '0;
      shift_q       <= lane_sym;
      tx_word_start <= 1'b1;
      tx_rd         <= rd_chain[0];
      if (in_valid && !in_legal) code_err <= 1'b1;
    end else begin
      bit_cnt       <= bit_cnt + 6'd1;
      shift_q       <= {shift_q[WORD_BITS-2:0], 1'b0};
      tx_word_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_serial_tx.sv
// Bench for fc_serial_tx: bit-exact line model, hand-computed words and a comma-locked decoder.
module tb_fc_serial_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_k = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx_serial_data, tx_word_start, tx_rd, code_err;

  int total = 0;
  int bad = 0;

  localparam logic [39:0] IDLE_RDN = {10'h0FA, 10'h2A2, 10'h2AA, 10'h2AA};
  localparam logic [39:0] IDLE_RDP = {10'h305, 10'h2AD, 10'h2AA, 10'h2AA};
  localparam logic [39:0] D_WORD   = {10'h1D4, 10'h2D4, 10'h31B, 10'h0AB};

  // RD- codes of the 5b/6b and 3b/4b sub-blocks (x.7 entry is the primary P7).
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  int          ph = 39;
  logic        m_rd = 1'b0, m_err = 1'b0, exp_ws = 1'b0, had = 1'b0;
  bit          bitq[$];
  logic [39:0] obs = '0, last_word = '0, p;
  logic [9:0]  mon_sh = '0;
  bit          mon_lock = 1'b0;
  logic        mon_rd = 1'b0;
  int          mon_n = 0, n_sym = 0, n_acc = 0, cyc = 0;
  bit          dec_ok [2][1024];
  bit          dec_rd [2][1024];

  fc_serial_tx dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_k           (in_k),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .tx_serial_data (tx_serial_data),
    .tx_word_start  (tx_word_start),
    .tx_rd          (tx_rd),
    .code_err       (code_err)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Disparity rule: unbalanced and alternating sub-blocks are complemented at RD+.
  function automatic void enc(input logic [7:0] c, input logic k, input logic rd,
                              output logic [9:0] s, output logic rdo);
    logic [5:0] b6;
    logic [3:0] b4;
    logic       r;
    int         x, y;
    if (k) begin
      s   = rd ? 10'h305 : 10'h0FA;
      rdo = ~rd;
      return;
    end
    x  = int'(c[4:0]);
    y  = int'(c[7:5]);
    b6 = T6[x];
    r  = rd ^ ($countones(b6) != 3);
    if (rd && (($countones(b6) != 3) || x == 7)) b6 = ~b6;
    if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
      b4 = 4'b0111;
    else
      b4 = T4[y];
    rdo = r ^ ($countones(b4) != 2);
    if (r && (($countones(b4) != 2) || y == 3 || y == 7)) b4 = ~b4;
    s = {b6, b4};
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic rst);
    logic       eb, take;
    logic [31:0] w;
    logic [3:0]  kk;
    logic [9:0]  s;
    logic        r;
    @(negedge clk);
    eb = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
    chk("ser", 64'(tx_serial_data), 64'(eb));
    chk("wst", 64'(tx_word_start), 64'(exp_ws));
    chk("rdy", 64'(in_ready), 64'(ph == 39));
    chk("rd", 64'(tx_rd), 64'(m_rd));
    chk("err", 64'(code_err), 64'(m_err));
    obs = {obs[38:0], tx_serial_data};
    if (ph == 39 && had) last_word = obs;
    mon_sh = {mon_sh[8:0], tx_serial_data};
    if (!mon_lock) begin
      if (mon_sh == 10'h0FA) begin mon_lock = 1'b1; mon_n = 0; mon_rd = 1'b1; n_sym++; end
    end else begin
      mon_n++;
      if (mon_n == 10) begin
        mon_n = 0;
        n_sym++;
        chk("dec", 64'(dec_ok[mon_rd][mon_sh]), 64'd1);
        if (dec_ok[mon_rd][mon_sh]) mon_rd = dec_rd[mon_rd][mon_sh];
      end
    end
    in_valid = v; in_data = d; in_k = k; reset_n = ~rst;
    exp_ws = 1'b0;
    if (rst) begin
      ph = 39; bitq.delete(); m_rd = 1'b0; m_err = 1'b0; had = 1'b0;
      mon_lock = 1'b0; mon_sh = '0;
    end else if (ph == 39) begin
      take = v && (k[2:0] == 3'b000) && (!k[3] || d[31:24] == 8'hBC);
      if (v && !take) m_err = 1'b1;
      if (take) n_acc++;
      w  = take ? d : 32'hBC95B5B5;
      kk = take ? k : 4'b1000;
      for (int i = 3; i >= 0; i--) begin
        enc(w[i*8 +: 8], kk[i], m_rd, s, r);
        m_rd = r;
        for (int b = 9; b >= 0; b--) bitq.push_back(s[b]);
      end
      exp_ws = 1'b1; had = 1'b1; ph = 0;
    end else begin
      ph++;
    end
  endtask

  // Offers one word at the next load edge; prev returns the word that just finished.
  task automatic word(input logic v, input logic [31:0] d, input logic [3:0] k, output logic [39:0] prev);
    int n = 0;
    while (ph != 39 && n < 80) begin step(1'b0, '0, '0, 1'b0); n++; end
    chk("sync", 64'(ph == 39), 64'd1);
    step(v, d, k, 1'b0);
    prev = last_word;
    repeat (39) step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [9:0]  s;
    logic        ro;
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 256; c++) begin
        enc(8'(c), 1'b0, 1'(r), s, ro);
        dec_ok[r][s] = 1'b1; dec_rd[r][s] = ro;
      end
      enc(8'hBC, 1'b1, 1'(r), s, ro);
      dec_ok[r][s] = 1'b1; dec_rd[r][s] = ro;
    end

    repeat (2) @(posedge clk);
    repeat (3) step(1'b0, '0, '0, 1'b1);

    word(1'b0, '0, '0, p);
    word(1'b0, '0, '0, p);
    chk("idle_rdn", 64'(p), 64'(IDLE_RDN));
    chk("idle_rd0", 64'(tx_rd), 64'd0);
    word(1'b1, 32'h01020304, 4'b0000, p);
    chk("idle_rdn2", 64'(p), 64'(IDLE_RDN));
    chk("dword_rd", 64'(tx_rd), 64'd1);
    word(1'b0, '0, '0, p);
    chk("dword", 64'(p), 64'(D_WORD));
    word(1'b0, '0, '0, p);
    chk("idle_rdp", 64'(p), 64'(IDLE_RDP));
    chk("idle_rd1", 64'(tx_rd), 64'd1);

    word(1'b1, 32'h12345678, 4'b0100, p);
    chk("kerr_set", 64'(code_err), 64'd1);
    word(1'b0, '0, '0, p);
    chk("kerr_fill", 64'(p), 64'(IDLE_RDP));
    chk("kerr_hold", 64'(code_err), 64'd1);

    // Abandon a word mid-flight with reset.
    step(1'b1, 32'hCAFE0123, 4'b0000, 1'b0);
    repeat (17) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    @(posedge clk);
    #1 chk("rst_mid_ser", 64'(tx_serial_data), 64'd0);
    step(1'b0, '0, '0, 1'b0);
    word(1'b0, '0, '0, p);
    word(1'b0, '0, '0, p);
    chk("rst_comma", 64'(p[39:30]), 64'h0FA);
    chk("rst_err_clr", 64'(code_err), 64'd0);

    // Random legal traffic, inputs changing every cycle.
    n_acc = 0;
    while (n_acc < 1000 && cyc < 60000) begin
      v = ($urandom_range(15) != 0);
      d = $urandom;
      if ($urandom_range(7) == 0) begin d[31:24] = 8'hBC; k = 4'b1000; end
      else k = 4'b0000;
      step(v, d, k, 1'b0);
      cyc++;
    end
    chk("rand_acc", 64'(n_acc >= 1000), 64'd1);
    chk("mon_syms", 64'(n_sym >= 4000), 64'd1);
    chk("mon_lock", 64'(mon_lock), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
